// File: rtl/dispatch_if.sv
// rtl/dispatch_if.sv - launch and per-core handshake bundle for the block dispatcher
interface dispatch_if #(
    parameter int NUM_CORES         = 2,
    parameter int THREADS_PER_BLOCK = 4
);
    localparam int TCW = $clog2(THREADS_PER_BLOCK) + 1;

    logic                       start;
    logic [7:0]                 thread_count;
    logic [NUM_CORES-1:0]       core_done;
    logic [NUM_CORES-1:0]       core_start;
    logic [NUM_CORES-1:0]       core_reset;
    logic [8*NUM_CORES-1:0]     core_block_id;
    logic [TCW*NUM_CORES-1:0]   core_thread_count;
    logic                       done;

    modport master (
        output start, thread_count, core_done,
        input  core_start, core_reset, core_block_id, core_thread_count, done
    );

    modport slave (
        input  start, thread_count, core_done,
        output core_start, core_reset, core_block_id, core_thread_count, done
    );
endinterface

// File: rtl/dispatch.sv
// rtl/dispatch.sv - splits a kernel launch into blocks and hands them to free cores
module dispatch #(
    parameter int NUM_CORES         = 2,
    parameter int THREADS_PER_BLOCK = 4
) (
    input  logic      clk,
    input  logic      reset,
    dispatch_if.slave bus
);
    localparam int TCW = $clog2(THREADS_PER_BLOCK) + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    state_e state_q, state_d;
    logic [7:0] tc_q, tc_d;
    logic [7:0] total_blocks_q, total_blocks_d;
    logic [7:0] blocks_dispatched_q, blocks_dispatched_d;
    logic [7:0] blocks_done_q, blocks_done_d;
    logic [NUM_CORES-1:0] core_start_q, core_start_d;
    logic [NUM_CORES-1:0] core_reset_q, core_reset_d;
    logic [NUM_CORES-1:0][7:0]     block_id_q, block_id_d;
    logic [NUM_CORES-1:0][TCW-1:0] thread_cnt_q, thread_cnt_d;
    logic done_q, done_d;

    logic [7:0] running;
    logic [7:0] last_tc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q             <= S_IDLE;
            tc_q                <= '0;
            total_blocks_q      <= '0;
            blocks_dispatched_q <= '0;
            blocks_done_q       <= '0;
            core_start_q        <= '0;
            core_reset_q        <= '1;
            block_id_q          <= '0;
            thread_cnt_q        <= '0;
            done_q              <= 1'b0;
        end else begin
            state_q             <= state_d;
            tc_q                <= tc_d;
            total_blocks_q      <= total_blocks_d;
            blocks_dispatched_q <= blocks_dispatched_d;
            blocks_done_q       <= blocks_done_d;
            core_start_q        <= core_start_d;
            core_reset_q        <= core_reset_d;
            block_id_q          <= block_id_d;
            thread_cnt_q        <= thread_cnt_d;
            done_q              <= done_d;
        end
    end

    always_comb begin
        state_d             = state_q;
        tc_d                = tc_q;
        total_blocks_d      = total_blocks_q;
        blocks_dispatched_d = blocks_dispatched_q;
        blocks_done_d       = blocks_done_q;
        core_start_d        = core_start_q;
        core_reset_d        = core_reset_q;
        block_id_d          = block_id_q;
        thread_cnt_d        = thread_cnt_q;
        done_d              = done_q;
        running             = blocks_dispatched_q;
        // Modulo-256 arithmetic is exact here since the remainder never exceeds 255.
        last_tc             = tc_q - 8'(THREADS_PER_BLOCK) * (total_blocks_q - 8'd1);

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    tc_d                = bus.thread_count;
                    total_blocks_d      = 8'((9'(bus.thread_count) + 9'(THREADS_PER_BLOCK - 1))
                                             / 9'(THREADS_PER_BLOCK));
                    blocks_dispatched_d = '0;
                    blocks_done_d       = '0;
                    state_d             = (bus.thread_count == 8'd0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                // Free/busy tests use registered state, so a core released this cycle waits one cycle.
                for (int c = 0; c < NUM_CORES; c++) begin
                    if (core_start_q[c] && !core_reset_q[c] && bus.core_done[c]) begin
                        core_start_d[c] = 1'b0;
                        core_reset_d[c] = 1'b1;
                        blocks_done_d   = blocks_done_d + 8'd1;
                    end
                    if (core_reset_q[c] && !core_start_q[c] && (running < total_blocks_q)) begin
                        core_reset_d[c] = 1'b0;
                        core_start_d[c] = 1'b1;
                        block_id_d[c]   = running;
                        thread_cnt_d[c] = (running == total_blocks_q - 8'd1) ? TCW'(last_tc)
                                                                             : TCW'(THREADS_PER_BLOCK);
                        running         = running + 8'd1;
                    end
                end
                blocks_dispatched_d = running;
                if (blocks_done_q == total_blocks_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            S_DONE: begin
                done_d       = 1'b1;
                core_start_d = '0;
                core_reset_d = '1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.core_start        = core_start_q;
    assign bus.core_reset        = core_reset_q;
    assign bus.core_block_id     = block_id_q;
    assign bus.core_thread_count = thread_cnt_q;
    assign bus.done              = done_q;
endmodule

// File: doc/dispatch.md
# dispatch

Kernel-level block dispatcher that sits directly upstream of the compute cores. On `start` it latches the kernel thread count and splits it into blocks of `THREADS_PER_BLOCK` threads. It hands each block to a free core by supplying a block ID and a per-block thread count, then asserting that core's start. It tracks block completions through each core's `done` and raises `done` once every block has finished.

## Interface
Parameters:
- `NUM_CORES`, 2: number of cores driven.
- `THREADS_PER_BLOCK`, 4: threads per full block; must be at least 1.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `start`  in  1  kernel launch request; sampled in IDLE only.
- `thread_count`  in  8  total kernel threads; latched when the launch is accepted.
- `core_done`  in  NUM_CORES  per-core block-complete flag.
- `core_start`  out  NUM_CORES  per-core start; held high while the core owns a block.
- `core_reset`  out  NUM_CORES  per-core reset; high while the core is free.
- `core_block_id`  out  8·NUM_CORES  block index for core c, at bits [8c+7:8c].
- `core_thread_count`  out  TCW·NUM_CORES  threads in core c's block, where TCW = $clog2(THREADS_PER_BLOCK)+1.
- `done`  out  1  all blocks complete.

## Operation
- Top FSM states:
  - IDLE: waits for a launch.
  - RUN: assigns blocks and counts completions.
  - DONE: terminal.
- Per-core condition, with no separate state bits:
  - free: `core_reset[c]`=1 and `core_start[c]`=0.
  - busy: `core_reset[c]`=0 and `core_start[c]`=1.
- Internal registers, all 8 bits:
  - `total_blocks`
  - `blocks_dispatched`
  - `blocks_done`
  - latched thread count `tc`.
- IDLE, on a cycle with `start`=1:
  - `tc` <= `thread_count`.
  - `total_blocks` <= ceil(`thread_count`/`THREADS_PER_BLOCK`), computed at 9-bit width to avoid overflow.
  - Both counters clear to 0.
  - If `thread_count`=0, go to DONE. Otherwise go to RUN.
- RUN, per clock, evaluating cores in ascending index:
  - Completion: if core c is busy and `core_done[c]`=1, then `core_start[c]`<=0, `core_reset[c]`<=1, and `blocks_done` increments.
  - Assignment: if core c is free on entry to this cycle and the running dispatched count is below `total_blocks`, then:
    - `core_reset[c]`<=0, `core_start[c]`<=1.
    - `core_block_id[c]` <= running dispatched count.
    - `core_thread_count[c]` <= `THREADS_PER_BLOCK`, or `tc` − `THREADS_PER_BLOCK`·(`total_blocks`−1) for the last block.
    - Running count increments.
  - Several cores may be assigned in one cycle. `blocks_dispatched` advances by the number assigned.
  - Several cores may complete in one cycle. `blocks_done` advances by the popcount of completions.
  - A core completing in cycle N is free from N+1 and is reassigned no earlier than N+1. It therefore sees `core_reset`=1 for at least one cycle between blocks.
  - If registered `blocks_done` == `total_blocks`: go to DONE, `done`<=1.
- DONE:
  - `done` is held at 1. All cores are held free.
  - `start` and `core_done` are ignored.
  - The only exit is `reset`.
- Edge-case rules:
  - `core_done` on a free core is ignored.
  - `thread_count` changes after the launch is accepted are ignored.
  - `core_block_id` and `core_thread_count` hold their value while the core is free.

## Timing
- Reset values (any cycle, including mid-RUN; takes effect at the next edge):
  - FSM = IDLE.
  - `core_reset` = all 1s; `core_start`, `done`, `core_block_id`, `core_thread_count` = 0.
  - All counters = 0.
- Launch latency: `start` sampled at edge E puts the FSM in RUN after E. The first `core_start` rises after edge E+1, i.e. visible 2 cycles after `start`.
- Completion latency: `core_done[c]` sampled at edge N drops `core_start[c]` and raises `core_reset[c]` after N. `blocks_done` updates after N. If that was the last block, `done` rises after N+1.
- `thread_count`=0: `done` rises after E+1 with no `core_start` pulse.
- Throughput: up to NUM_CORES assignments and NUM_CORES completions per cycle.

## Test plan
- NUM_CORES=2, TPB=4, `thread_count`=8, `start` for 1 cycle:
  - Both cores start in the same cycle: block_id 0/1, thread_count 4/4.
  - Pulse both `core_done` together, so `blocks_done` advances by 2.
  - `done`=1 one cycle later.
- `thread_count`=10:
  - Blocks 0 and 1 go to cores 0 and 1.
  - `core_done[1]` raises `core_reset[1]` for at least 1 cycle.
  - Core 1 then gets block_id 2 with thread_count 2.
  - `done` rises only after all 3 completions.
- `thread_count`=0 → `done`=1 two cycles after `start`, and `core_start` stays 0 throughout.
- TPB=1, `thread_count`=255:
  - 255 blocks dispatched with ids 0..254, each with thread_count 1.
  - No counter wrap; `done` rises after completion 255.
- `core_done[1]` pulsed while core 1 is free → ignored, no `blocks_done` change. Changing `thread_count` mid-RUN → no effect on `total_blocks`.
- Reset asserted mid-RUN with a core busy:
  - Next cycle shows all `core_reset`=1, `core_start`=0, `done`=0, FSM in IDLE.
  - A relaunch with `thread_count`=4 dispatches block 0 normally.
